// File: rtl/pci_initiator_fsm.sv
// PCI bus-master transaction controller: arbitrates, frames read/write bursts,
// and handles DEVSEL timeout, target disconnect and latency-timer preemption.
module pci_initiator_fsm #(
   parameter int MAX_BURST      = 8,
   parameter int DEVSEL_TIMEOUT = 5,
   parameter int LAT_TIMER      = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             rd_wr,
   input  logic [$clog2(MAX_BURST+1)-1:0]   len,
   input  logic                             gnt,
   input  logic                             devsel,
   input  logic                             trdy,
   input  logic                             stop,
   output logic                             req,
   output logic                             frame,
   output logic                             irdy,
   output logic [2:0]                       state,
   output logic [$clog2(MAX_BURST+1)-1:0]   beat_count,
   output logic                             fvalid,
   output logic                             done,
   output logic                             abort
);

   localparam int LW = $clog2(MAX_BURST + 1);
   localparam int TW = (LAT_TIMER > 0) ? $clog2(LAT_TIMER + 1) : 1;
   localparam int DW = $clog2(DEVSEL_TIMEOUT + 1);

   localparam logic [LW-1:0] MAX_L    = LW'(MAX_BURST);
   localparam logic [TW-1:0] LAT_L    = TW'(LAT_TIMER);
   localparam logic [DW-1:0] DEV_LAST = DW'(DEVSEL_TIMEOUT - 1);
   localparam logic [DW-1:0] DEV_MAX  = DW'(DEVSEL_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      REQUEST    = 3'd1,
      ADDRESS    = 3'd2,
      TURNAROUND = 3'd3,
      DATA       = 3'd4,
      FINISH     = 3'd5,
      ABORT      = 3'd6
   } state_e;

   state_e          state_q, state_d;
   logic            rd_wr_q, rd_wr_d;
   logic [LW-1:0]   eff_len_q, eff_len_d;
   logic [LW-1:0]   beat_q, beat_d;
   logic [TW-1:0]   lat_q, lat_d;
   logic [DW-1:0]   dev_q, dev_d;
   logic            claimed_q, claimed_d;
   logic            req_q, req_d;
   logic            frame_q, frame_d;
   logic            irdy_q, irdy_d;
   logic            fvalid_w;

   function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
      if (l == '0)
         return LW'(1);
      else if (l > MAX_L)
         return MAX_L;
      else
         return l;
   endfunction

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
      return (v == '0) ? '0 : v - TW'(1);
   endfunction

   assign fvalid_w = (state_q == DATA) && !irdy_q && !trdy;

   always_comb begin
      state_d   = state_q;
      rd_wr_d   = rd_wr_q;
      eff_len_d = eff_len_q;
      beat_d    = beat_q;
      lat_d     = lat_q;
      dev_d     = dev_q;
      claimed_d = claimed_q;
      frame_d   = 1'b1;

      // DEVSEL watch runs from the cycle after the address phase until claimed
      if (state_q == TURNAROUND || state_q == DATA) begin
         if (!devsel)
            claimed_d = 1'b1;
         else if (!claimed_q && dev_q != DEV_MAX)
            dev_d = dev_q + DW'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = REQUEST;
               rd_wr_d   = rd_wr;
               eff_len_d = clamp_len(len);
            end
         end
         REQUEST: begin
            if (!gnt)
               state_d = ADDRESS;
         end
         ADDRESS:    state_d = rd_wr_q ? TURNAROUND : DATA;
         TURNAROUND: state_d = DATA;
         DATA: begin
            lat_d = sat_dec(lat_q);
            if (!claimed_q && devsel && dev_q >= DEV_LAST) begin
               state_d = ABORT;
            end else begin
               if (fvalid_w)
                  beat_d = beat_q + LW'(1);
               if ((fvalid_w && frame_q) || !stop)
                  state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         ABORT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_d == ADDRESS) begin
         beat_d    = '0;
         lat_d     = LAT_L;
         dev_d     = '0;
         claimed_d = 1'b0;
      end

      // Bus lines are registered from the next state; FRAME# rises for the last phase and then stays up
      case (state_d)
         ADDRESS, TURNAROUND: frame_d = 1'b0;
         DATA: frame_d = (state_q == DATA && frame_q) ||
                         ((beat_d + LW'(1)) == eff_len_q) ||
                         (lat_d == '0 && gnt);
         default: frame_d = 1'b1;
      endcase
      req_d  = (state_d != REQUEST);
      irdy_d = (state_d != DATA);
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         lat_q     <= '0;
         dev_q     <= '0;
         claimed_q <= 1'b0;
         req_q     <= 1'b1;
         frame_q   <= 1'b1;
         irdy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         lat_q     <= lat_d;
         dev_q     <= dev_d;
         claimed_q <= claimed_d;
         req_q     <= req_d;
         frame_q   <= frame_d;
         irdy_q    <= irdy_d;
      end
   end

   always_ff @(negedge clk) begin
      rd_wr_q   <= rd_wr_d;
      eff_len_q <= eff_len_d;
   end

   assign req        = req_q;
   assign frame      = frame_q;
   assign irdy       = irdy_q;
   assign state      = state_q;
   assign beat_count = beat_q;
   assign fvalid     = fvalid_w;
   assign done       = (state_q == FINISH);
   assign abort      = (state_q == ABORT);

endmodule
